// File: rtl/store_merge_queue_pkg.sv
// store_merge_queue_pkg: line geometry and line address/data/mask types shared by the store merge queue
package store_merge_queue_pkg;
  localparam int LINE_BYTES = 64;
  localparam int ADDR_WIDTH = 26;
  typedef logic [ADDR_WIDTH-1:0] line_addr_t;
  typedef logic [8*LINE_BYTES-1:0] line_data_t;
  typedef logic [LINE_BYTES-1:0] line_mask_t;
endpackage

// File: rtl/line_byte_merge.sv
// line_byte_merge: per-byte select, merged byte = mask ? new_data : old_data (ports old_data, new_data, mask -> merged)
module line_byte_merge
  import store_merge_queue_pkg::*;
(
  input  line_data_t old_data,
  input  line_data_t new_data,
  input  line_mask_t mask,
  output line_data_t merged
);
  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_byte
    assign merged[8*b+:8] = mask[b] ? new_data[8*b+:8] : old_data[8*b+:8];
  end
endmodule

// File: rtl/store_merge_queue.sv
// store_merge_queue: merging line store FIFO to L2 (store_*, l2_req_*) with byte-masked load bypass (lookup_addr_i -> bypass_*) and empty_o
module store_merge_queue
  import store_merge_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       store_en_i,
  input  line_addr_t store_addr_i,
  input  line_data_t store_data_i,
  input  line_mask_t store_mask_i,
  output logic       store_ready_o,
  input  line_addr_t lookup_addr_i,
  output logic       bypass_hit_o,
  output line_mask_t bypass_mask_o,
  output line_data_t bypass_data_o,
  output logic       l2_req_valid_o,
  output line_addr_t l2_req_addr_o,
  output line_data_t l2_req_data_o,
  output line_mask_t l2_req_mask_o,
  input  logic       l2_req_ack_i,
  output logic       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [DEPTH-1:0] valid;
  line_addr_t [DEPTH-1:0] addr;
  line_data_t [DEPTH-1:0] data;
  line_mask_t [DEPTH-1:0] mask;
  logic [PW-1:0] head, tail, st_idx, lk_idx, wr_idx;
  logic [PW:0] count;
  logic st_hit, lk_hit, head_hit, accept, alloc, ack_fire;
  line_data_t st_old, st_merged, head_data;
  line_mask_t head_mask, lk_mask;
  always_comb begin
    st_hit = 1'b0;
    st_idx = '0;
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && PW'(i) != head && addr[i] == store_addr_i) begin
        st_hit = 1'b1;
        st_idx = PW'(i);
      end
      if (valid[i] && PW'(i) != head && addr[i] == lookup_addr_i) begin
        lk_hit = 1'b1;
        lk_idx = PW'(i);
      end
    end
  end
  assign store_ready_o = count != FULL;
  assign accept = store_en_i && store_ready_o && |store_mask_i;
  assign alloc = accept && !st_hit;
  assign ack_fire = l2_req_ack_i && valid[head];
  assign wr_idx = st_hit ? st_idx : tail;
  // merging against zero on allocate clears the unwritten bytes
  assign st_old = st_hit ? data[st_idx] : '0;
  line_byte_merge u_store_merge (
    .old_data(st_old),
    .new_data(store_data_i),
    .mask(store_mask_i),
    .merged(st_merged)
  );
  assign head_hit = valid[head] && addr[head] == lookup_addr_i;
  assign head_data = head_hit ? data[head] : '0;
  assign head_mask = head_hit ? mask[head] : '0;
  assign lk_mask = lk_hit ? mask[lk_idx] : '0;
  line_byte_merge u_bypass_merge (
    .old_data(head_data),
    .new_data(data[lk_idx]),
    .mask(lk_mask),
    .merged(bypass_data_o)
  );
  assign bypass_mask_o = head_mask | lk_mask;
  assign bypass_hit_o = |bypass_mask_o;
  assign empty_o = count == '0;
  assign l2_req_valid_o = !empty_o;
  assign l2_req_addr_o = addr[head];
  assign l2_req_data_o = data[head];
  assign l2_req_mask_o = mask[head];
  // an acked slot is cleared so the L2 port reads zero once the queue drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      addr <= '0;
      data <= '0;
      mask <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (ack_fire) begin
        valid[head] <= 1'b0;
        addr[head] <= '0;
        data[head] <= '0;
        mask[head] <= '0;
        head <= head + PW'(1);
      end
      if (accept) begin
        valid[wr_idx] <= 1'b1;
        addr[wr_idx] <= store_addr_i;
        data[wr_idx] <= st_merged;
        mask[wr_idx] <= (st_hit ? mask[st_idx] : '0) | store_mask_i;
      end
      if (alloc) tail <= tail + PW'(1);
      count <= count + (PW+1)'(alloc) - (PW+1)'(ack_fire);
    end
  end
endmodule

// File: tb/tb_store_merge_queue.sv
// tb_store_merge_queue: randomized scoreboard bench for store_merge_queue against a queue-based line model
module tb_store_merge_queue;
  import store_merge_queue_pkg::*;
  localparam int DEPTH = 8;
  typedef struct {
    line_addr_t addr;
    line_data_t data;
    line_mask_t mask;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic store_en_i = 1'b0;
  logic l2_req_ack_i = 1'b0;
  line_addr_t store_addr_i = '0;
  line_addr_t lookup_addr_i = '0;
  line_data_t store_data_i = '0;
  line_mask_t store_mask_i = '0;
  logic store_ready_o, bypass_hit_o, l2_req_valid_o, empty_o;
  line_mask_t bypass_mask_o, l2_req_mask_o;
  line_data_t bypass_data_o, l2_req_data_o;
  line_addr_t l2_req_addr_o;
  ent_t model[$];
  ent_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic exp_ready = 1'b1, exp_empty = 1'b1, exp_valid = 1'b0, exp_hit = 1'b0;
  line_mask_t exp_bmask = '0, exp_lmask = '0;
  line_data_t exp_bdata = '0, exp_ldata = '0;
  line_addr_t exp_laddr = '0;
  store_merge_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .store_en_i(store_en_i),
    .store_addr_i(store_addr_i),
    .store_data_i(store_data_i),
    .store_mask_i(store_mask_i),
    .store_ready_o(store_ready_o),
    .lookup_addr_i(lookup_addr_i),
    .bypass_hit_o(bypass_hit_o),
    .bypass_mask_o(bypass_mask_o),
    .bypass_data_o(bypass_data_o),
    .l2_req_valid_o(l2_req_valid_o),
    .l2_req_addr_o(l2_req_addr_o),
    .l2_req_data_o(l2_req_data_o),
    .l2_req_mask_o(l2_req_mask_o),
    .l2_req_ack_i(l2_req_ack_i),
    .empty_o(empty_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask
  function automatic line_data_t rdata();
    line_data_t d;
    for (int k = 0; k < 16; k++) d[32*k+:32] = $urandom();
    return d;
  endfunction
  function automatic line_mask_t rmask();
    line_mask_t m;
    m = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: m = '0;
      1: m = m & {$urandom(), $urandom()};
      2: m = '1;
      3: m = 64'(1) << $urandom_range(0, 63);
      default: ;
    endcase
    return m;
  endfunction
  // expected combinational outputs for the current model contents and lookup address
  task automatic set_exp();
    ent_t e;
    exp_ready = model.size() != DEPTH;
    exp_empty = model.size() == 0;
    exp_valid = !exp_empty;
    exp_laddr = '0;
    exp_ldata = '0;
    exp_lmask = '0;
    exp_bmask = '0;
    exp_bdata = '0;
    if (model.size() > 0) begin
      e = model[0];
      exp_laddr = e.addr;
      exp_ldata = e.data;
      exp_lmask = e.mask;
      if (e.addr == lookup_addr_i) begin
        exp_bmask = e.mask;
        exp_bdata = e.data;
      end
    end
    for (int j = 1; j < model.size(); j++) begin
      e = model[j];
      if (e.addr == lookup_addr_i)
        for (int b = 0; b < LINE_BYTES; b++)
          if (e.mask[b]) begin
            exp_bmask[b] = 1'b1;
            exp_bdata[8*b+:8] = e.data[8*b+:8];
          end
    end
    exp_hit = exp_bmask != '0;
  endtask
  task automatic step(input logic en, input line_addr_t a, input line_data_t d, input line_mask_t m,
                      input logic ack, input line_addr_t la);
    ent_t e;
    bit had, found;
    @(posedge clk);
    #1;
    store_en_i = en;
    store_addr_i = a;
    store_data_i = d;
    store_mask_i = m;
    l2_req_ack_i = ack;
    lookup_addr_i = la;
    set_exp();
    had = model.size() > 0;
    if (exp_ready && en && m != '0) begin
      found = 0;
      for (int j = 1; j < model.size(); j++) begin
        e = model[j];
        if (e.addr == a) begin
          for (int b = 0; b < LINE_BYTES; b++) if (m[b]) e.data[8*b+:8] = d[8*b+:8];
          e.mask = e.mask | m;
          model[j] = e;
          found = 1;
        end
      end
      if (!found) begin
        e.addr = a;
        e.mask = m;
        e.data = '0;
        for (int b = 0; b < LINE_BYTES; b++) if (m[b]) e.data[8*b+:8] = d[8*b+:8];
        model.push_back(e);
      end
    end
    if (ack && had) begin
      exp_q.push_back(model[0]);
      void'(model.pop_front());
    end
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    store_en_i = 1'b0;
    l2_req_ack_i = 1'b0;
    #1;
    chk("rst_store_ready", store_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_l2_valid", l2_req_valid_o, 0);
    chk("rst_bypass_hit", bypass_hit_o, 0);
    chk("rst_bypass_mask", bypass_mask_o, 0);
    chk("rst_bypass_data", bypass_data_o, 0);
    chk("rst_l2_addr", l2_req_addr_o, 0);
    chk("rst_l2_data", l2_req_data_o, 0);
    chk("rst_l2_mask", l2_req_mask_o, 0);
    model.delete();
    exp_q.delete();
    set_exp();
    #1;
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      chk("store_ready", store_ready_o, exp_ready);
      chk("empty", empty_o, exp_empty);
      chk("l2_valid", l2_req_valid_o, exp_valid);
      chk("l2_addr", l2_req_addr_o, exp_laddr);
      chk("l2_mask", l2_req_mask_o, exp_lmask);
      chk("l2_data", l2_req_data_o, exp_ldata);
      chk("bypass_hit", bypass_hit_o, exp_hit);
      chk("bypass_mask", bypass_mask_o, exp_bmask);
      chk("bypass_data", bypass_data_o, exp_bdata);
      if (l2_req_valid_o && l2_req_ack_i) begin
        chk("sb_expected_ack", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ent_t e;
          e = exp_q.pop_front();
          chk("sb_addr", l2_req_addr_o, e.addr);
          chk("sb_mask", l2_req_mask_o, e.mask);
          chk("sb_data", l2_req_data_o, e.data);
        end
      end
    end
  end
  initial begin
    line_data_t d;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    d = '0;
    d[7:0] = 8'hAA;
    step(1, 'h10, d, 64'h1, 0, 'h10);
    step(0, '0, '0, '0, 0, 'h10);
    step(0, '0, '0, '0, 1, 'h10);
    step(0, '0, '0, '0, 0, 'h10);
    step(1, 'h10, rdata(), 64'h1, 0, 'h20);
    step(1, 'h20, rdata(), 64'h1, 0, 'h20);
    step(1, 'h20, rdata(), 64'h2, 0, 'h20);
    step(1, 'h10, rdata(), 64'h1, 0, 'h10);
    step(0, '0, '0, '0, 0, 'h10);
    repeat (4) step(0, '0, '0, '0, 1, 'h10);
    for (int i = 0; i < DEPTH; i++) step(1, line_addr_t'('h100 + i), rdata(), '1, 0, line_addr_t'('h100 + i));
    step(1, 'h200, rdata(), '1, 1, 'h200);
    step(1, 'h201, rdata(), '1, 0, 'h201);
    step(0, '0, '0, '0, 0, 'h107);
    repeat (DEPTH + 1) step(0, '0, '0, '0, 1, 'h201);
    for (int i = 0; i < 3; i++) step(1, line_addr_t'('h300 + i), rdata(), rmask() | 64'h1, 0, 'h300);
    step(1, 'h3ff, rdata(), '1, 1, 'h3ff);
    repeat (4) step(0, '0, '0, '0, 1, 'h3ff);
    for (int i = 0; i < 5; i++) step(1, line_addr_t'('h400 + i), rdata(), '1, 0, 'h400);
    step(0, '0, '0, '0, 0, 'h400);
    async_reset();
    step(0, '0, '0, '0, 1, 'h400);
    for (int i = 0; i < 3000; i++) begin
      int ack_pct;
      ack_pct = (i / 250) % 3 == 0 ? 15 : (i / 250) % 3 == 1 ? 50 : 85;
      step($urandom_range(0, 99) < 70, line_addr_t'($urandom_range(0, 5)), rdata(), rmask(),
           $urandom_range(0, 99) < ack_pct, line_addr_t'($urandom_range(0, 6)));
      if (i == 1800) async_reset();
    end
    repeat (DEPTH + 2) step(0, '0, '0, '0, 1, '0);
    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
